// File: rtl/sdram_arb_pkg.sv
// Shared types for the two-requester SDRAM arbiter: FSM states, grant owner
// and master-port constants.
package sdram_arb_pkg;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] RESET_ADDR = 28'h8000000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_WR = 2'd1,
    GRANT_RD = 2'd2
  } arb_state_e;

  typedef enum logic {
    WR = 1'b0,
    RD = 1'b1
  } owner_e;

endpackage

// File: rtl/sdram_arb_pending_cnt.sv
// Outstanding-read counter: up on accepted read, down on returned data,
// saturating at both ends so stray returns or a full window never wrap it.
module sdram_arb_pending_cnt #(
  parameter int MAX_PENDING = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_empty
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [PW-1:0] LIM = PW'(MAX_PENDING);

  logic [PW-1:0] r_cnt;

  // Simultaneous issue and return cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != LIM)) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_full  = (r_cnt == LIM);
  assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/sdram_arbiter.sv
// Two-requester SDRAM master-port arbiter: frame-flush writer vs texture
// reader, alternating bounded bursts with one idle bubble between grants.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_MAX   = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_write,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_wdata,
  output logic              wr_waitrequest,
  input  logic              rd_read,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              rd_waitrequest,
  output logic [DATA_W-1:0] rd_readdata,
  output logic              rd_readdatavalid,
  output logic              SD_write,
  output logic              SD_read,
  output logic [ADDR_W-1:0] SD_address,
  output logic [DATA_W-1:0] SD_wdata,
  input  logic              SD_waitrequest,
  input  logic [DATA_W-1:0] SD_readdata,
  input  logic              SD_readdatavalid,
  output logic              busy
);

  localparam int BW = $clog2(BURST_MAX) + 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

  arb_state_e    r_state;
  owner_e        r_last;
  logic [BW-1:0] r_beats;

  logic          w_gnt_wr;
  logic          w_gnt_rd;
  logic          w_full;
  logic          w_empty;
  logic          w_acc;
  logic          w_acc_rd;
  logic          w_cmd;
  logic          w_wr_ok;
  logic [BW-1:0] w_beats_nxt;

  // Gating by reset makes an abort visible in the same cycle it is asserted.
  assign w_gnt_wr = (r_state == GRANT_WR) && !reset;
  assign w_gnt_rd = (r_state == GRANT_RD) && !reset;

  assign SD_write   = w_gnt_wr && wr_write;
  assign SD_read    = w_gnt_rd && rd_read && !w_full;
  assign SD_address = w_gnt_wr ? wr_address : (w_gnt_rd ? rd_address : '0);
  assign SD_wdata   = w_gnt_wr ? wr_wdata : '0;

  assign wr_waitrequest = !w_gnt_wr || SD_waitrequest;
  assign rd_waitrequest = !w_gnt_rd || w_full || SD_waitrequest;

  assign rd_readdata      = SD_readdata;
  assign rd_readdatavalid = SD_readdatavalid;

  assign w_acc       = (SD_write || SD_read) && !SD_waitrequest;
  assign w_acc_rd    = SD_read && !SD_waitrequest;
  assign w_cmd       = (r_state == GRANT_WR) ? wr_write : rd_read;
  assign w_beats_nxt = r_beats + {{(BW-1){1'b0}}, w_acc};

  // Writes may not overtake reads still in flight.
  assign w_wr_ok = wr_write && w_empty;

  assign busy = (r_state != IDLE) || !w_empty;

  sdram_arb_pending_cnt #(
    .MAX_PENDING (MAX_PENDING)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .i_inc   (w_acc_rd),
    .i_dec   (SD_readdatavalid),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_beats <= '0;
      r_last  <= RD;
    end else begin
      case (r_state)
        IDLE: begin
          r_beats <= '0;
          if (w_wr_ok && rd_read) begin
            r_state <= (r_last == RD) ? GRANT_WR : GRANT_RD;
          end else if (w_wr_ok) begin
            r_state <= GRANT_WR;
          end else if (rd_read) begin
            r_state <= GRANT_RD;
          end
        end
        GRANT_WR, GRANT_RD: begin
          if (!w_cmd || (w_beats_nxt == BURST_LIM)) begin
            r_state <= IDLE;
            r_beats <= '0;
            r_last  <= (r_state == GRANT_WR) ? WR : RD;
          end else begin
            r_beats <= w_beats_nxt;
          end
        end
        default: begin
          r_state <= IDLE;
          r_beats <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: cycle model compared every cycle, plus directed
// scenarios with literal burst-length and latency expectations.
module tb_sdram_arbiter;

  localparam int BURST = 16;
  localparam int MAXP  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_write = 1'b0;
  logic [27:0] wr_address = '0;
  logic [31:0] wr_wdata = '0;
  logic        wr_waitrequest;
  logic        rd_read = 1'b0;
  logic [27:0] rd_address = '0;
  logic        rd_waitrequest;
  logic [31:0] rd_readdata;
  logic        rd_readdatavalid;
  logic        SD_write;
  logic        SD_read;
  logic [27:0] SD_address;
  logic [31:0] SD_wdata;
  logic        SD_waitrequest = 1'b0;
  logic [31:0] SD_readdata;
  logic        SD_readdatavalid;
  logic        busy;

  // resp_mode 1: slave returns each read in the cycle it is accepted.
  int          resp_mode = 0;
  logic        man_valid = 1'b0;
  logic [31:0] man_data = '0;

  assign SD_readdatavalid = (resp_mode == 1) ? (SD_read && !SD_waitrequest) : man_valid;
  assign SD_readdata      = (resp_mode == 1) ? {4'hD, SD_address} : man_data;

  always #5 clk = ~clk;

  sdram_arbiter #(.BURST_MAX(BURST), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset(reset),
    .wr_write(wr_write), .wr_address(wr_address), .wr_wdata(wr_wdata),
    .wr_waitrequest(wr_waitrequest),
    .rd_read(rd_read), .rd_address(rd_address), .rd_waitrequest(rd_waitrequest),
    .rd_readdata(rd_readdata), .rd_readdatavalid(rd_readdatavalid),
    .SD_write(SD_write), .SD_read(SD_read), .SD_address(SD_address),
    .SD_wdata(SD_wdata), .SD_waitrequest(SD_waitrequest),
    .SD_readdata(SD_readdata), .SD_readdatavalid(SD_readdatavalid),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: owner 0 none, 1 writer, 2 reader; last 1 writer, 2 reader.
  int m_own = 0, m_beats = 0, m_pend = 0, m_last = 2;
  logic e_gw, e_gr, e_full, e_sdw, e_sdr, e_ww, e_rw, e_busy, e_accw, e_accr;
  logic [27:0] e_addr;
  logic [31:0] e_wdata;

  always_comb begin
    e_gw    = !reset && (m_own == 1);
    e_gr    = !reset && (m_own == 2);
    e_full  = (m_pend == MAXP);
    e_sdw   = e_gw && wr_write;
    e_sdr   = e_gr && rd_read && !e_full;
    e_ww    = !(e_gw && !SD_waitrequest);
    e_rw    = !(e_gr && !e_full && !SD_waitrequest);
    e_busy  = (m_own != 0) || (m_pend != 0);
    e_accw  = e_sdw && !SD_waitrequest;
    e_accr  = e_sdr && !SD_waitrequest;
    e_addr  = e_gw ? wr_address : (e_gr ? rd_address : 28'h0);
    e_wdata = e_gw ? wr_wdata : 32'h0;
  end

  always @(posedge clk) begin
    if (reset) begin
      m_own <= 0; m_beats <= 0; m_pend <= 0; m_last <= 2;
    end else begin
      if (e_accr && !SD_readdatavalid) m_pend <= m_pend + 1;
      else if (!e_accr && SD_readdatavalid && m_pend > 0) m_pend <= m_pend - 1;
      if (m_own == 0) begin
        if (wr_write && m_pend == 0 && rd_read) m_own <= (m_last == 2) ? 1 : 2;
        else if (wr_write && m_pend == 0) m_own <= 1;
        else if (rd_read) m_own <= 2;
      end else if (!((m_own == 1) ? wr_write : rd_read) ||
                   (m_beats + int'(e_accw || e_accr) == BURST)) begin
        m_own <= 0; m_beats <= 0; m_last <= m_own;
      end else begin
        m_beats <= m_beats + int'(e_accw || e_accr);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctl", {58'd0, SD_write, SD_read, wr_waitrequest, rd_waitrequest, busy, rd_readdatavalid},
                 {58'd0, e_sdw, e_sdr, e_ww, e_rw, e_busy, SD_readdatavalid});
      chk("addr",  {36'd0, SD_address}, {36'd0, e_addr});
      chk("wdata", {32'd0, SD_wdata},   {32'd0, e_wdata});
      chk("rdata", {32'd0, rd_readdata}, {32'd0, SD_readdata});
    end
  end

  // Burst-run recorder: each run encoded as owner*100 + accepted beats.
  int runs[$];
  int cur_own = 0, cur_len = 0, last_acc = 0, cyc_no = 0, samp_cyc = 0;

  task automatic flush();
    if (cur_len > 0) runs.push_back(cur_own * 100 + cur_len);
    cur_len = 0;
    cur_own = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    samp_cyc = cyc_no;
    last_acc = (SD_write && !SD_waitrequest) ? 1 : ((SD_read && !SD_waitrequest) ? 2 : 0);
    if (last_acc == 0 || last_acc != cur_own) flush();
    if (last_acc != 0) begin
      cur_own = last_acc;
      cur_len++;
    end
    @(posedge clk);
    #1;
    cyc_no++;
  endtask

  task automatic do_reset();
    wr_write = 0; rd_read = 0; man_valid = 0; SD_waitrequest = 0;
    reset = 1;
    repeat (2) cyc();
    reset = 0;
    #1;
    chk("rst_cmd",  {62'd0, SD_write, SD_read}, 64'd0);
    chk("rst_wait", {62'd0, wr_waitrequest, rd_waitrequest}, 64'd3);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_addr", {36'd0, SD_address}, 64'd0);
    chk_en = 1;
    flush();
    runs.delete();
  endtask

  task automatic chk_runs(input string name, input int n, input int e0, input int e1, input int e2);
    int exp[3];
    exp = '{e0, e1, e2};
    flush();
    chk({name, "_n"}, 64'(runs.size() >= n), 64'd1);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_run%0d", name, i), 64'(i < runs.size() ? runs[i] : -1), 64'(exp[i]));
    runs.delete();
  endtask

  initial begin
    int sent, n, wn, rn, drop_c, first_rd, last_v, first_w, wacc;

    // Single writer for 40 beats: 16 + 16 + 8.
    do_reset();
    wr_write = 1; sent = 0; n = 0;
    while (sent < 40 && n < 200) begin
      wr_address = 28'h0100000 + 28'(sent * 4);
      wr_wdata   = 32'hA500_0000 + 32'(sent);
      cyc();
      if (last_acc == 1) sent++;
      n++;
    end
    wr_write = 0; cyc();
    chk("wr40_sent", 64'(sent), 64'd40);
    chk_runs("wr40", 3, 116, 116, 108);

    // Simultaneous first requests: writer wins, reader after one bubble.
    do_reset();
    resp_mode = 1;
    wr_write = 1; rd_read = 1; wn = 0; rn = 0; n = 0; drop_c = -1; first_rd = -1;
    while (rn < 3 && n < 100) begin
      if (wn == 4 && wr_write) begin wr_write = 0; drop_c = cyc_no; end
      wr_address = 28'h0200000 + 28'(wn * 4);
      rd_address = 28'h0300000 + 28'(rn * 4);
      cyc();
      if (last_acc == 1) wn++;
      if (last_acc == 2) begin if (first_rd < 0) first_rd = samp_cyc; rn++; end
      n++;
    end
    rd_read = 0; cyc();
    chk("tie_bubble", 64'(first_rd - drop_c), 64'd2);
    chk_runs("tie", 2, 104, 203, 0);

    // Both held: alternating full bursts.
    do_reset();
    resp_mode = 1;
    wr_write = 1; rd_read = 1;
    for (int i = 0; i < 60; i++) begin
      wr_address = 28'h0400000 + 28'(i * 4);
      wr_wdata   = 32'h5A00_0000 + 32'(i);
      rd_address = 28'h0500000 + 28'(i * 4);
      cyc();
    end
    wr_write = 0; rd_read = 0; cyc(); cyc();
    chk_runs("alt", 3, 116, 216, 116);

    // No read returns: window fills at MAX_PENDING, one return frees one slot.
    do_reset();
    resp_mode = 0;
    rd_read = 1;
    for (int i = 0; i < 20; i++) begin
      rd_address = 28'h0600000 + 28'(i * 4);
      cyc();
    end
    chk("full_sdread", {63'd0, SD_read}, 64'd0);
    chk("full_rdwait", {63'd0, rd_waitrequest}, 64'd1);
    man_valid = 1; man_data = 32'hCAFE_0001; cyc();
    man_valid = 0;
    repeat (4) cyc();
    rd_read = 0; cyc();
    chk_runs("full", 2, 208, 201, 0);

    // Reads outstanding block the writer until all have returned.
    do_reset();
    resp_mode = 0;
    rd_read = 1; rn = 0; n = 0;
    while (rn < 4 && n < 50) begin
      rd_address = 28'h0700000 + 28'(rn * 4);
      cyc();
      if (last_acc == 2) rn++;
      n++;
    end
    rd_read = 0;
    wr_write = 1; wr_address = 28'h0800000; wacc = 0;
    for (int i = 0; i < 10; i++) begin cyc(); if (last_acc == 1) wacc++; end
    for (int i = 0; i < 4; i++) begin
      man_valid = 1; man_data = 32'hBEEF_0000 + 32'(i);
      cyc();
      if (last_acc == 1) wacc++;
    end
    man_valid = 0; last_v = samp_cyc;
    chk("ord_blocked", 64'(wacc), 64'd0);
    first_w = -1; n = 0;
    while (first_w < 0 && n < 20) begin
      cyc();
      if (last_acc == 1) first_w = samp_cyc;
      n++;
    end
    chk("ord_wr_lat", 64'(first_w - last_v), 64'd2);
    wr_write = 0; cyc();

    // Reset mid-grant while the slave stalls.
    do_reset();
    SD_waitrequest = 1; wr_write = 1; wr_address = 28'h0900000;
    repeat (3) cyc();
    chk("abort_pre", {63'd0, SD_write}, 64'd1);
    reset = 1; cyc(); reset = 0;
    chk("abort_sdw", {63'd0, SD_write}, 64'd0);
    chk("abort_wait", {62'd0, wr_waitrequest, rd_waitrequest}, 64'd3);
    wr_write = 0; SD_waitrequest = 0;
    man_valid = 1; man_data = 32'h0BAD_0BAD; cyc();
    man_valid = 0; cyc();
    chk("stray_busy", {63'd0, busy}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter BURST_MAX, default 16: maximum accepted transfers per grant before forced re-arbitration.
REQ-002 Parameter MAX_PENDING, default 8: maximum reads issued but not yet returned.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 wr_write  in  1  requester 0 (frame flush writer) write request.
REQ-006 wr_address  in  28  requester 0 byte address.
REQ-007 wr_wdata  in  32  requester 0 write data.
REQ-008 wr_waitrequest  out  1  requester 0 stall; low = transfer accepted this cycle.
REQ-009 rd_read  in  1  requester 1 (texture fetch) read request.
REQ-010 rd_address  in  28  requester 1 byte address.
REQ-011 rd_waitrequest  out  1  requester 1 stall; low = transfer accepted this cycle.
REQ-012 rd_readdata  out  32  read data returned to requester 1.
REQ-013 rd_readdatavalid  out  1  rd_readdata valid this cycle.
REQ-014 SD_write, SD_read  out  1 each  master-side commands.
REQ-015 SD_address  out  28;  SD_wdata  out  32  master-side address/data.
REQ-016 SD_waitrequest  in  1;  SD_readdata  in  32;  SD_readdatavalid  in  1  slave responses.
REQ-017 busy  out  1  high whenever state is not IDLE or reads are pending.

Function
REQ-018 FSM states IDLE, GRANT_WR, GRANT_RD; exactly one requester is connected to the master port per cycle, the other sees waitrequest=1.
REQ-019 IDLE: if exactly one request is asserted, grant it next cycle; if both, grant the one not served last (last_grant register, reset value = RD, so WR wins first tie).
REQ-020 Command outputs are combinational pass-through of the granted requester's signals gated by state; zero-cycle added latency inside a grant.
REQ-021 Accepted transfer = granted command high and SD_waitrequest low; beat counter (width clog2(BURST_MAX)+1) increments on each accepted transfer.
REQ-022 Grant ends when the granted requester drops its command or the beat counter reaches BURST_MAX; next cycle returns to IDLE, counter clears, last_grant updated.
REQ-023 IDLE cycle between grants is mandatory (one bubble), so no command is driven while in IDLE.
REQ-024 Pending counter: +1 on accepted read, -1 on SD_readdatavalid, unchanged if both in same cycle.
REQ-025 GRANT_RD masks SD_read and holds rd_waitrequest high while pending == MAX_PENDING.
REQ-026 GRANT_WR is not entered from IDLE while pending != 0 (write/read ordering); wr request waits, read may be re-granted.
REQ-027 SD_readdata/SD_readdatavalid forwarded combinationally to rd_readdata/rd_readdatavalid regardless of state.
REQ-028 SD_readdatavalid with pending == 0 is ignored for counting (counter does not underflow).
REQ-029 Addresses are passed unmodified; no address arithmetic or width change.

Reset
REQ-030 On reset: state=IDLE, beat counter=0, pending=0, last_grant=RD; all SD command outputs low, SD_address/SD_wdata=0, both waitrequest outputs high, busy low from first cycle after reset.
REQ-031 Reset asserted mid-grant aborts the grant the next clock edge; in-flight read returns after reset are dropped.

Structure
REQ-032 Package sdram_arb_pkg holds the state enum and a grant-owner enum (WR, RD) plus the reset address constant 28'h8000000.
REQ-033 One sub-module natural: sdram_arb_pending_cnt (saturating up/down counter for REQ-024/025/028); all else in one module.

Verification
REQ-034 Only wr_write held for 40 beats, SD_waitrequest=0 -> grants of 16,16,8 beats each separated by one IDLE bubble; SD_address tracks wr_address.
REQ-035 wr_write and rd_read asserted same cycle after reset -> WR granted first; after WR drops, RD granted after one bubble.
REQ-036 Both held continuously -> alternating 16-beat grants WR,RD,WR; neither requester starves.
REQ-037 RD with SD_readdatavalid never asserted -> exactly 8 reads accepted, then SD_read low and rd_waitrequest high until a valid returns.
REQ-038 4 reads pending, wr_write asserted -> no GRANT_WR until 4 SD_readdatavalid pulses received; pending=0 then WR granted.
REQ-039 reset pulsed mid-WR grant with SD_waitrequest=1 -> next cycle SD_write=0, state IDLE, both waitrequests high.
